// File: rtl/sisa_pkg.sv
// sisa_pkg: shared definitions for the sISA sequencer.
//   - opcode_t : 2-bit major opcode held in instr[7:6]
//   - state_t  : sequencer FSM states
//   - field bit positions inside the 8-bit instruction word
package sisa_pkg;

  // Major opcode. OP_JMPH is shared by JMP ([5] = 0) and HALT ([5] = 1).
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_LI   = 2'b01,
    OP_BEQ  = 2'b10,
    OP_JMPH = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction field positions.
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int RD_MSB   = 5;   // rd for ADD/LI, compared register for BEQ
  localparam int RD_LSB   = 4;
  localparam int RS_MSB   = 1;
  localparam int RS_LSB   = 0;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;
  localparam int HALT_BIT = 5;   // distinguishes HALT from JMP within OP_JMPH

endpackage

// File: rtl/program_counter.sv
// program_counter: PC_W-bit program counter.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset, PC -> 0
//   inc      in   advance PC by one (wraps modulo 2^PC_W)
//   load     in   load PC from load_val (takes priority over inc)
//   load_val in   branch/jump target
//   pc       out  current program counter
module program_counter #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // PC register: reset, load, increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/sisa_sequencer.sv
// sisa_sequencer: multi-cycle fetch/decode/execute control unit for the sCPU.
// Fetches 8-bit sISA instructions from a synchronous ROM, drives the ALU and
// register-file controls, resolves BEQ using the ALU equal flag and owns the PC.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   run              start/continue execution (level)
//   instr_addr       ROM address (= PC)
//   instr_data       ROM data, valid one cycle after instr_addr
//   rs_sel, rd_sel   register-file read selects (rd_sel is also write target)
//   imm              4-bit immediate to the ALU
//   add              1 = ALU outputs the sum, 0 = ALU outputs zero-extended imm
//   reg_we           register-file write enable (one-cycle pulse in WB)
//   equal            ALU comparator result, used only in EXEC of a BEQ
//   retired_cnt      16-bit retired-instruction counter, present only when
//                    the macro SISA_RETIRE_CNT_EN is defined
//   halted           high while in HALT
module sisa_sequencer
  import sisa_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int RSEL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [7:0]        instr_data,
  output logic [RSEL_W-1:0] rs_sel,
  output logic [RSEL_W-1:0] rd_sel,
  output logic [3:0]        imm,
  output logic              add,
  output logic              reg_we,
  input  logic              equal,
`ifdef SISA_RETIRE_CNT_EN
  output logic [15:0]       retired_cnt,
`endif
  output logic              halted
);

  state_t          state;
  logic [7:0]      ir;
  opcode_t         ir_op;
  opcode_t         dec_op;
  logic            pc_inc;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic            ir_unused;

  assign ir_op  = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign dec_op = opcode_t'(instr_data[OP_MSB:OP_LSB]);
  // ir[4] is only meaningful through rd_sel, which is captured directly.
  assign ir_unused = ir[RD_LSB];

  // Target is the zero-extended immediate, truncated to the PC width.
  assign pc_target = PC_W'(ir[IMM_MSB:IMM_LSB]);

  // PC control: BEQ/JMP resolve in EXEC, ADD/LI advance in WB, HALT freezes.
  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (state)
      S_EXEC: begin
        if (ir_op == OP_BEQ) begin
          if (equal) begin
            pc_load = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
        end else if (ir_op == OP_JMPH && !ir[HALT_BIT]) begin
          pc_load = 1'b1;
        end else begin
          pc_load = 1'b0;
        end
      end
      S_WB: begin
        pc_inc = 1'b1;
      end
      default: begin
        pc_inc  = 1'b0;
        pc_load = 1'b0;
      end
    endcase
  end

  program_counter #(
    .PC_W(PC_W)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (pc_target),
    .pc       (instr_addr)
  );

  // Sequencer FSM with registered decode outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ir     <= 8'h00;
      rs_sel <= '0;
      rd_sel <= '0;
      imm    <= 4'h0;
      add    <= 1'b0;
      reg_we <= 1'b0;
      halted <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          // ROM data for the address presented in FETCH is valid now.
          ir     <= instr_data;
          rd_sel <= RSEL_W'(instr_data[RD_MSB:RD_LSB]);
          // BEQ compares the register named in [5:4] against R0.
          rs_sel <= (dec_op == OP_BEQ) ? RSEL_W'(instr_data[RD_MSB:RD_LSB])
                                       : RSEL_W'(instr_data[RS_MSB:RS_LSB]);
          imm    <= instr_data[IMM_MSB:IMM_LSB];
          add    <= (dec_op == OP_ADD);
          state  <= S_EXEC;
        end
        S_EXEC: begin
          case (ir_op)
            OP_ADD, OP_LI: begin
              reg_we <= 1'b1;
              state  <= S_WB;
            end
            OP_BEQ: begin
              state <= run ? S_FETCH : S_IDLE;
            end
            OP_JMPH: begin
              if (ir[HALT_BIT]) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                state <= run ? S_FETCH : S_IDLE;
              end
            end
            default: begin
              state <= S_IDLE;
            end
          endcase
        end
        S_WB: begin
          state <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          halted <= 1'b1;
          state  <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SISA_RETIRE_CNT_EN
  logic retire;

  // Every completed non-HALT instruction moves the PC exactly once.
  assign retire = pc_inc | pc_load;

  // Retired-instruction counter, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= 16'h0000;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 16'h0001;
    end else begin
      retired_cnt <= retired_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_sisa_sequencer.sv
// Testbench for sisa_sequencer: ROM and register file around the DUT, and an
// instruction-level reference model that predicts PC flow, register writes,
// output fields and cycle timing per instruction.
module tb_sisa_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [1:0] rs_sel;
  logic [1:0] rd_sel;
  logic [3:0] imm;
  logic       add;
  logic       reg_we;
  logic       equal;
  logic       halted;
`ifdef SISA_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  int checks;
  int failures;

  // Environment: ROM, register file
  logic [7:0] rom [0:15];
  logic [7:0] rf  [0:3];
  logic       rf_clear;

  // Reference model state
  logic [3:0]  m_pc;
  logic [7:0]  m_rf [0:3];
  logic [15:0] m_retired;

  sisa_sequencer #(.PC_W(4), .RSEL_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .rs_sel     (rs_sel),
    .rd_sel     (rd_sel),
    .imm        (imm),
    .add        (add),
    .reg_we     (reg_we),
    .equal      (equal),
`ifdef SISA_RETIRE_CNT_EN
    .retired_cnt(retired_cnt),
`endif
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= rom[instr_addr];

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (reg_we) begin
      rf[rd_sel] <= add ? (rf[rd_sel] + rf[rs_sel]) : {4'h0, imm};
    end
  end

  assign equal = (rf[rs_sel] == rf[0]);

  task automatic do_reset();
    reset = 1'b1;
    rf_clear = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rf_clear = 1'b0;
    m_pc = 4'h0;
    m_retired = 16'h0000;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
  endtask

  // Called at a negedge while in IDLE: start running, land in FETCH.
  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
  endtask

  // Execute one instruction starting at a negedge in FETCH; ends in FETCH
  // (or HALT for a HALT instruction).
  task automatic exec_one(input logic run_after);
    logic [7:0] ins;
    logic [1:0] op, rd, rs;
    logic [3:0] im;
    logic       is_halt;
    ins = rom[m_pc];
    op = ins[7:6]; rd = ins[5:4]; rs = ins[1:0]; im = ins[3:0];
    is_halt = (op == 2'b11) && ins[5];
    // FETCH
    checks++;
    if (instr_addr !== m_pc) begin failures++; $display("FAIL fetch_addr got=%0d exp=%0d", instr_addr, m_pc); end
    checks++;
    if (reg_we !== 1'b0) begin failures++; $display("FAIL we_fetch got=%b exp=0 pc=%0d", reg_we, m_pc); end
    @(negedge clk); // DECODE
    checks++;
    if (reg_we !== 1'b0) begin failures++; $display("FAIL we_decode got=%b exp=0 pc=%0d", reg_we, m_pc); end
    @(negedge clk); // EXEC
    run = run_after;
    checks++;
    if (reg_we !== 1'b0) begin failures++; $display("FAIL we_exec got=%b exp=0 pc=%0d", reg_we, m_pc); end
    checks++;
    if (add !== (op == 2'b00)) begin failures++; $display("FAIL add_exec got=%b exp=%b ins=%h", add, (op == 2'b00), ins); end
    if (op == 2'b00) begin
      checks++;
      if (rd_sel !== rd || rs_sel !== rs) begin failures++; $display("FAIL add_sel got=%0d/%0d exp=%0d/%0d", rd_sel, rs_sel, rd, rs); end
    end else if (op == 2'b01) begin
      checks++;
      if (rd_sel !== rd || imm !== im) begin failures++; $display("FAIL li_fields got=%0d/%h exp=%0d/%h", rd_sel, imm, rd, im); end
    end else if (op == 2'b10) begin
      checks++;
      if (rs_sel !== rd || imm !== im) begin failures++; $display("FAIL beq_fields got=%0d/%h exp=%0d/%h", rs_sel, imm, rd, im); end
    end else begin
      checks++;
      if (imm !== im) begin failures++; $display("FAIL jmp_imm got=%h exp=%h", imm, im); end
    end
    @(negedge clk);
    if (is_halt) begin
      checks++;
      if (halted !== 1'b1 || instr_addr !== m_pc) begin failures++; $display("FAIL halt_enter got=%b/%0d exp=1/%0d", halted, instr_addr, m_pc); end
      return;
    end
    if (op[1] == 1'b0) begin
      // WB cycle
      checks++;
      if (reg_we !== 1'b1 || rd_sel !== rd) begin failures++; $display("FAIL wb_pulse got=%b/%0d exp=1/%0d", reg_we, rd_sel, rd); end
      m_rf[rd] = (op == 2'b00) ? (m_rf[rd] + m_rf[rs]) : {4'h0, im};
      m_pc = m_pc + 4'd1;
      m_retired = m_retired + 16'd1;
      @(negedge clk);
      checks++;
      if (rf[rd] !== m_rf[rd]) begin failures++; $display("FAIL wb_value r%0d got=%h exp=%h", rd, rf[rd], m_rf[rd]); end
      checks++;
      if (reg_we !== 1'b0) begin failures++; $display("FAIL we_after_wb got=%b exp=0", reg_we); end
    end else begin
      if (op == 2'b10) m_pc = (m_rf[rd] == m_rf[0]) ? im : m_pc + 4'd1;
      else m_pc = im;
      m_retired = m_retired + 16'd1;
    end
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL halted_spurious got=%b exp=0", halted); end
`ifdef SISA_RETIRE_CNT_EN
    checks++;
    if (retired_cnt !== m_retired) begin failures++; $display("FAIL retired got=%0d exp=%0d", retired_cnt, m_retired); end
`endif
    if (!run_after) begin
      // Parked in IDLE with PC already advanced.
      repeat (2) begin
        checks++;
        if (instr_addr !== m_pc || reg_we !== 1'b0) begin failures++; $display("FAIL idle_park got=%0d/%b exp=%0d/0", instr_addr, reg_we, m_pc); end
        @(negedge clk);
      end
      run = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({instr_addr, rs_sel, rd_sel, imm, add, reg_we, halted} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%0d/%0d/%h/%b/%b/%b exp=all0", instr_addr, rs_sel, rd_sel, imm, add, reg_we, halted);
    end
`ifdef SISA_RETIRE_CNT_EN
    checks++;
    if (retired_cnt !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired_cnt); end
`endif
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (instr_addr !== 4'd0 || reg_we !== 1'b0) begin failures++; $display("FAIL idle_hold got=%0d/%b exp=0/0", instr_addr, reg_we); end
    end
  endtask

  task automatic test_directed();
    logic run_pat [0:10];
    for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
    rom[0] = 8'h5A; rom[1] = 8'h11; rom[2] = 8'h94; rom[3] = 8'h01;
    rom[4] = 8'h97; rom[7] = 8'hCF; rom[15] = 8'h7F;
    for (int i = 0; i < 11; i++) run_pat[i] = 1'b1;
    run_pat[2] = 1'b0; run_pat[5] = 1'b0; run_pat[10] = 1'b0;
    do_reset();
    start_run();
    for (int i = 0; i < 11; i++) exec_one(run_pat[i]);
  endtask

  task automatic test_halt();
    for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
    rom[0] = 8'h5A;
    do_reset();
    start_run();
    exec_one(1'b1);
    exec_one(1'b1);
    repeat (8) begin
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || instr_addr !== 4'd1 || reg_we !== 1'b0) begin
        failures++;
        $display("FAIL halt_sticky got=%b/%0d/%b exp=1/1/0", halted, instr_addr, reg_we);
      end
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || instr_addr !== 4'd0) begin failures++; $display("FAIL halt_reset got=%b/%0d exp=0/0", halted, instr_addr); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) rom[i] = 8'h5A;
    do_reset();
    start_run();
    @(negedge clk); // DECODE of LI R1,10
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_addr, rs_sel, rd_sel, imm, add, reg_we, halted} !== 15'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h/%0d/%0d/%h/%b/%b/%b exp=all0", instr_addr, rs_sel, rd_sel, imm, add, reg_we, halted);
    end
    reset = 1'b0;
    run = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (reg_we !== 1'b0 || instr_addr !== 4'd0 || rf[1] !== 8'h00) begin
        failures++;
        $display("FAIL midreset_nowrite got=%b/%0d/%h exp=0/0/00", reg_we, instr_addr, rf[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = 8'($urandom);
        if (rom[i][7:6] == 2'b11) rom[i][5] = 1'b0;
      end
      do_reset();
      start_run();
      for (int n = 0; n < 30; n++) exec_one($urandom_range(0, 3) != 0);
    end
  endtask

`ifdef SISA_RETIRE_CNT_EN
  task automatic test_retire();
    for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
    rom[0] = 8'h51; rom[1] = 8'h11; rom[2] = 8'hC0;
    do_reset();
    start_run();
    for (int i = 0; i < 9; i++) exec_one(1'b1);
    checks++;
    if (retired_cnt !== 16'd9) begin failures++; $display("FAIL retire_nine got=%0d exp=9", retired_cnt); end
    do_reset();
    checks++;
    if (retired_cnt !== 16'd0) begin failures++; $display("FAIL retire_reset got=%0d exp=0", retired_cnt); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    run = 1'b0;
    rf_clear = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
    test_reset();
    test_directed();
    test_halt();
    test_reset_mid();
    test_random();
`ifdef SISA_RETIRE_CNT_EN
    test_retire();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sisa_sequencer.md
Name: sisa_sequencer

Overview:
- Multi-cycle control unit for the sCPU; sits directly upstream of the ALU.
- Fetches 8-bit sISA instructions from a synchronous instruction ROM and decodes them.
- Drives the ALU select (`add`), the 4-bit immediate, register-file read/write selects and write enable.
- Consumes the ALU `equal` flag to resolve branches and owns the program counter.

Parameters:
- PC_W, 4, program counter / instruction address width (16-entry ROM)
- RSEL_W, 2, register select width (4 registers, R0..R3)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; start/continue execution from IDLE
- instr_addr  out  PC_W  ROM address (= PC)
- instr_data  in  8  ROM read data, valid one cycle after instr_addr is presented
- rs_sel  out  RSEL_W  register-file read select feeding ALU B / comparator
- rd_sel  out  RSEL_W  read select for ALU A and the write-back target
- imm  out  4  immediate to ALU
- add  out  1  1 = ALU_out is the adder sum, 0 = ALU_out is the zero-extended imm
- reg_we  out  1  register-file write enable, one-cycle pulse
- equal  in  1  ALU comparator result (B == R0)
- halted  out  1  high in HALT state

Behaviour:
- Encoding, op = instr[7:6]:
  - 00 ADD: R[rd] = R[rd] + R[rs]; rd = [5:4], rs = [1:0].
  - 01 LI: R[rd] = imm; rd = [5:4], imm = [3:0].
  - 10 BEQ: if R[[5:4]] == R0 then PC = imm, else PC + 1; rs_sel = [5:4].
  - 11 with [5] = 0 is JMP (PC = imm); with [5] = 1 is HALT.
- States: IDLE -> FETCH -> DECODE -> EXEC -> (WB | IDLE/FETCH) ... HALT.
  - IDLE: PC held; when run = 1, go to FETCH.
  - FETCH: instr_addr = PC; go to DECODE.
  - DECODE: latch instr_data into the IR; drive the decoded fields; go to EXEC.
  - EXEC: selects stable; sample `equal` for BEQ.
    - ADD/LI: go to WB.
    - BEQ/JMP: update PC; go to FETCH if run, else IDLE.
    - HALT: go to HALT.
  - WB: reg_we = 1 for exactly this cycle; PC = PC + 1; go to FETCH if run, else IDLE.
  - HALT: sticky until reset; halted = 1.
- Latency: ADD/LI take 4 cycles; BEQ/JMP take 3 cycles.
- PC increment wraps modulo 2^PC_W (15 -> 0). Branch targets are zero-extended imm, truncated to PC_W.
- `add` = 1 only for ADD; 0 otherwise.
- imm, rs_sel, rd_sel are driven from the IR and held from DECODE through WB.
- Reset values: PC = 0, IR = 0, state = IDLE, add = 0, reg_we = 0, imm = 0, rs_sel = 0, rd_sel = 0, halted = 0.
- Reset in any state, including mid-instruction, aborts with no write (reg_we = 0 in the reset cycle) and returns to IDLE.
- run deasserted mid-instruction: the instruction completes; the machine parks in IDLE with PC already advanced.
- `equal` is ignored in every state except EXEC of a BEQ.

Optional Feature:
- Macro: SISA_RETIRE_CNT_EN.
- Defined:
  - Extra output retired_cnt (16 bits), reset to 0.
  - Increments once per completed instruction: at WB for ADD/LI, at EXEC for BEQ/JMP. HALT is not counted.
  - Wraps 0xFFFF -> 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package sisa_pkg holds:
  - opcode constants OP_ADD, OP_LI, OP_BEQ, OP_JMPH;
  - the state enum/localparams S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT;
  - instruction field bit positions.
- One sub-module, program_counter: PC_W register with hold, increment, load and synchronous reset.
- FSM and decode stay in sisa_sequencer.

Test Plan:
- Reset, then run = 1, ROM[0] = 0x5A (LI R1, 10) -> cycle 4 shows rd_sel = 1, imm = 0xA, add = 0, reg_we = 1 for one cycle; instr_addr then = 1.
- ROM[1] = 0x11 (ADD R1, R1) -> add = 1, rd_sel = 1, rs_sel = 1, reg_we pulse in WB; PC 1 -> 2.
- BEQ 0x93 (rs = 1, target 3) with equal = 1 at EXEC -> next instr_addr = 3 after 3 cycles with no reg_we. Same with equal = 0 -> instr_addr = PC + 1.
- ROM[15] = LI, executed -> PC wraps to 0. ROM[n] = 0xE0 (HALT) -> halted = 1, PC frozen, run toggling has no effect until reset.
- Assert reset during DECODE of an LI -> no reg_we pulse, state IDLE, PC = 0, all outputs at reset values.
- With SISA_RETIRE_CNT_EN: program LI, ADD, JMP 0 run for 9 instructions -> retired_cnt = 9; reset -> 0.
